mem_arbiter_rr: RTL

//  Parametrised memory-port arbiter for N_CH clients; successor to the fixed 4/8-channel priority arbiter.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/arb_rr_pick.sv | 49 ++++
 rtl/mem_arbiter_rr.sv | 101 ++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the memory-port arbiter
package arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  localparam int OH_MAX = 64;

  // Index of the set bit of a one-hot vector (0 when the vector is zero).
  function automatic int onehot2idx(input logic [OH_MAX-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < OH_MAX; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - combinational fixed/rotating priority picker
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int IW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] cand,
  input  logic [IW-1:0]   start_idx,
  input  arb_mode_t       mode,
  output logic [N_CH-1:0] pick_oh,
  output logic [IW-1:0]   pick_idx,
  output logic            pick_valid
);

  localparam logic [IW:0] NCH_W = (IW+1)'(N_CH);

  logic [IW-1:0]     off;
  logic [2*N_CH-1:0] dbl;
  logic [2*N_CH-1:0] shifted;
  logic [N_CH-1:0]   rot;
  logic [IW-1:0]     rel;
  logic [IW:0]       sum;
  logic              found;

  // Rotate the doubled candidate vector so the scan start sits at bit 0,
  // priority-encode the lowest set bit, then map it back modulo N_CH.
  always_comb begin
    off     = (mode == ARB_RR) ? start_idx : '0;
    dbl     = {cand, cand};
    shifted = dbl >> off;
    rot     = shifted[N_CH-1:0];
    found   = 1'b0;
    rel     = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        rel   = IW'(i);
      end
    end
    sum = {1'b0, off} + {1'b0, rel};
    if (sum >= NCH_W) sum = sum - NCH_W;
    pick_oh = '0;
    if (found) pick_oh[sum[IW-1:0]] = 1'b1;
    pick_valid = found;
    pick_idx   = IW'(onehot2idx(OH_MAX'(pick_oh)));
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - sticky-grant memory-port arbiter with hold limit
module mem_arbiter_rr
  import arb_pkg::*;
#(
  parameter int N_CH     = 8,
  parameter int MAX_HOLD = 16,
  parameter int IW       = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  arb_mode_t       mode,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] gnt,
  output logic            gnt_valid,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_new
);

  localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  // The counter stops at the preempt threshold so a holder that ran alone
  // for a long time is still preemptible once someone else shows up.
  localparam int              HOLD_CAP_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [HW-1:0]   HOLD_CAP   = HW'(HOLD_CAP_I);
  localparam logic [IW-1:0]   LAST_IDX   = IW'(N_CH - 1);

  logic [IW-1:0]   last_idx;
  logic [HW-1:0]   hold_cnt;

  logic [N_CH-1:0] others;
  logic            holding;
  logic            preempt;
  logic [N_CH-1:0] cand;
  logic [IW-1:0]   start_idx;
  logic [N_CH-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;

  logic [N_CH-1:0] gnt_d;
  logic [IW-1:0]   gnt_idx_d;
  logic            gnt_new_d;
  logic [IW-1:0]   last_idx_d;
  logic [HW-1:0]   hold_cnt_d;

  assign gnt_valid = |gnt;

  arb_rr_pick #(
    .N_CH (N_CH),
    .IW   (IW)
  ) u_pick (
    .cand       (cand),
    .start_idx  (start_idx),
    .mode       (mode),
    .pick_oh    (pick_oh),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  // Keep the current holder, preempt it at the hold limit, or pick anew.
  always_comb begin
    others     = req & ~gnt;
    holding    = |(req & gnt);
    preempt    = (MAX_HOLD != 0) && holding && (hold_cnt == HOLD_CAP) && (|others);
    cand       = preempt ? others : req;
    start_idx  = (last_idx == LAST_IDX) ? '0 : last_idx + 1'b1;

    gnt_d      = '0;
    gnt_idx_d  = '0;
    gnt_new_d  = 1'b0;
    last_idx_d = last_idx;
    hold_cnt_d = '0;

    if (holding && !preempt) begin
      gnt_d      = gnt;
      gnt_idx_d  = gnt_idx;
      hold_cnt_d = (hold_cnt == HOLD_CAP) ? hold_cnt : hold_cnt + 1'b1;
    end else if (pick_valid) begin
      gnt_d      = pick_oh;
      gnt_idx_d  = pick_idx;
      gnt_new_d  = 1'b1;
      last_idx_d = pick_idx;
    end
  end

  // Register the decision; reset drops any grant and re-aims RR at client 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt      <= '0;
      gnt_idx  <= '0;
      gnt_new  <= 1'b0;
      last_idx <= LAST_IDX;
      hold_cnt <= '0;
    end else begin
      gnt      <= gnt_d;
      gnt_idx  <= gnt_idx_d;
      gnt_new  <= gnt_new_d;
      last_idx <= last_idx_d;
      hold_cnt <= hold_cnt_d;
    end
  end

endmodule
